fp_itof_seq: RTL and testbench
==============================

Name: fp_itof_seq

Overview:
- Multi-cycle signed-integer to IEEE754 (NX, NM) converter with valid/ready handshakes on both sides.
- Upstream stage of the parametrised FP datapath: produces packed {sign, exp, mant} words for the FP arithmetic blocks and bench checkers.
- Normalises iteratively, one bit per cycle, then rounds round-to-nearest-even.

Parameters:
NX, 8, exponent width
NM, 23, mantissa (fraction) width
NI, 32, signed integer input width (NI >= 2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
in_valid  in  1  input word valid
in_ready  out  1  converter can accept
in_data  in  NI  two's-complement integer
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  NX+NM+1  packed {sign, exp, mant}
out_inexact  out  1  rounding discarded non-zero bits
out_ovf  out  1  result saturated to infinity

Behaviour:
- Interface: one clock CLK; RST is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_inexact=0, out_ovf=0. Asserting RST at any point aborts the conversion in flight. No output is produced for the aborted word.
- Constants:
  - XOFF = 2^(NX-1)-1.
  - EXP_MAX = 2^NX-1.
  - N = NX+NM+1.
- Registers: sign, mag[NI-1:0] (unsigned), exp (signed, NX+2 bits).
- IDLE:
  - in_ready=1; all other states drive in_ready=0.
  - A transfer occurs when in_valid && in_ready. On transfer, capture sign=in_data[NI-1] and mag=|in_data| as unsigned.
  - Most-negative input -2^(NI-1) gives mag=2^(NI-1), which is exact.
  - If mag==0: out_data=0 (+0), flags=0, next state DONE.
  - Otherwise exp=XOFF+NI-1, next state NORM.
- NORM:
  - If mag[NI-1]==1, next state ROUND.
  - Otherwise mag<<=1 and exp-=1 in the same cycle.
  - With LZ leading zeros, NORM lasts LZ+1 cycles.
- ROUND: the fraction is mag[NI-2:0].
  - If NI-1 <= NM: mant = fraction zero-padded on the right; exact, so inexact=0.
  - Otherwise:
    - mant = top NM fraction bits.
    - guard = next bit.
    - sticky = OR of the remaining bits.
    - inexact = guard|sticky.
    - Increment mant when guard && (sticky || mant[0]).
    - Mantissa carry-out: set mant=0 and exp+=1.
  - If exp >= EXP_MAX: out_data={sign, all-ones, 0}, out_ovf=1.
  - Next state DONE.
- DONE:
  - out_valid=1, with out_data and flags stable.
  - Hold until out_ready=1, then go to IDLE. out_valid falls on the next edge.
  - No new input is accepted in the acceptance cycle; throughput is one word per conversion.
- Latency: accept edge is cycle 0.
  - Non-zero input: out_valid first high in cycle LZ+3.
  - Zero input: out_valid first high in cycle 1.
- out_valid is never combinationally dependent on out_ready. in_ready is a registered function of state.
- Backpressure: while out_ready=0 in DONE, all outputs hold indefinitely.

Decomposition:
- Shared fp package:
  - reuse EXP_OFFSET, MAX.
  - add fp_itof state enum (IDLE, NORM, ROUND, DONE).
  - add function EXP_MAXV(NX).
- One natural combinational sub-module: fp_round_rne.
  - Inputs: fraction, exp.
  - Outputs: mant, exp', inexact, ovf.
  - Parametrised NX, NM, FW. It is reusable by downstream FP arithmetic stages.

Test Plan:
1. Default params, in_data=1, out_ready=1 -> out_data=0x3F800000, inexact=0, out_valid in cycle 34 (LZ=31).
2. in_data=-1 -> 0xBF800000; in_data=0 -> 0x00000000 with out_valid in cycle 1.
3. in_data=0x80000000 -> 0xCF000000, latency 3 cycles, inexact=0.
4. RNE rounding:
   - 16777217 -> 0x4B800000, inexact=1 (tie to even, down).
   - 16777219 -> 0x4B800002, inexact=1 (tie up).
   - 0x7FFFFFFF -> 0x4F000000, inexact=1 (mantissa carry into exponent).
5. NX=5, NM=10, NI=32, in_data=0x7FFFFFFF -> 0x7C00, out_ovf=1; in_data=-65536 -> 0xFC00, out_ovf=1.
6. Control:
   - Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0.
   - Assert RST mid-NORM -> next cycle in_ready=1, out_valid=0, no stale result emitted.
   - Back-to-back in_valid -> each word accepted only in IDLE.

Source files
------------

// File: rtl/fp_itof_seq_pkg.sv
// Shared FP helpers: exponent constants and the itof converter state encoding.
// Pure package, no logic; imported by the converter and the RNE rounding stage.
package fp_itof_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } itof_state_t;

    function automatic int EXP_OFFSET(input int nx);
        return (1 << (nx - 1)) - 1;
    endfunction

    function automatic int EXP_MAXV(input int nx);
        return (1 << nx) - 1;
    endfunction

    function automatic int MAX(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even of a normalised fraction to NM bits, zero latency.
// Saturates to infinity when the biased exponent reaches all-ones; no handshake.
module fp_round_rne
    import fp_itof_seq_pkg::*;
#(
    parameter int NX = 8,
    parameter int NM = 23,
    parameter int FW = 31
) (
    input  logic [FW-1:0]        i_frac,
    input  logic signed [NX+1:0] i_exp,
    output logic [NM-1:0]        o_mant,
    output logic [NX-1:0]        o_exp,
    output logic                 o_inexact,
    output logic                 o_ovf
);

    localparam int EXP_MAX = EXP_MAXV(NX);
    localparam logic signed [NX+1:0] EXP_LIM = (NX+2)'(EXP_MAX);

    logic [NM-1:0]        w_mant_t;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_inc;
    logic [NM:0]          w_sum;
    logic signed [NX+1:0] w_exp_r;

    generate
        if (FW <= NM) begin : g_exact
            assign w_mant_t = NM'(i_frac) << (NM - FW);
            assign w_guard  = 1'b0;
            assign w_sticky = 1'b0;
        end else begin : g_rnd
            assign w_mant_t = i_frac[FW-1 -: NM];
            assign w_guard  = i_frac[FW-1-NM];
            if (FW - NM >= 2) begin : g_stk
                assign w_sticky = |i_frac[FW-2-NM:0];
            end else begin : g_nostk
                assign w_sticky = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        w_inc     = w_guard & (w_sticky | w_mant_t[0]);
        w_sum     = {1'b0, w_mant_t} + {{NM{1'b0}}, w_inc};
        // a carry out of the mantissa leaves w_sum[NM-1:0] at zero, so only exp moves
        w_exp_r   = i_exp + $signed({{(NX+1){1'b0}}, w_sum[NM]});
        o_inexact = w_guard | w_sticky;
        o_ovf     = (w_exp_r >= EXP_LIM);
        o_mant    = w_sum[NM-1:0];
        o_exp     = w_exp_r[NX-1:0];
        if (o_ovf) begin
            o_mant = '0;
            o_exp  = '1;
        end
    end

endmodule

// File: rtl/fp_itof_seq.sv
// Signed int to packed FP, one normalise bit per cycle then RNE; latency LZ+3 (zero: 1).
// Result held in DONE until out_ready; no new word is accepted outside IDLE.
module fp_itof_seq
    import fp_itof_seq_pkg::*;
#(
    parameter int NX = 8,
    parameter int NM = 23,
    parameter int NI = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NI-1:0]     in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NX+NM:0]    out_data,
    output logic              out_inexact,
    output logic              out_ovf
);

    localparam int XOFF = EXP_OFFSET(NX);
    localparam logic signed [NX+1:0] EXP_INIT = (NX+2)'(XOFF + NI - 1);
    localparam logic signed [NX+1:0] EXP_ONE  = (NX+2)'(1);

    itof_state_t          r_state;
    itof_state_t          w_next;
    logic                 r_sign;
    logic [NI-1:0]        r_mag;
    logic signed [NX+1:0] r_exp;
    logic [NX+NM:0]       r_out_data;
    logic                 r_inexact;
    logic                 r_ovf;

    logic [NI-1:0]        w_abs;
    logic                 w_accept;
    logic [NM-1:0]        w_mant_o;
    logic [NX-1:0]        w_exp_o;
    logic                 w_inexact_o;
    logic                 w_ovf_o;

    // the most negative input wraps to 2^(NI-1), which is the correct unsigned magnitude
    assign w_abs    = in_data[NI-1] ? (-in_data) : in_data;
    assign w_accept = in_valid && (r_state == IDLE);

    fp_round_rne #(.NX(NX), .NM(NM), .FW(NI-1)) u_round (
        .i_frac    (r_mag[NI-2:0]),
        .i_exp     (r_exp),
        .o_mant    (w_mant_o),
        .o_exp     (w_exp_o),
        .o_inexact (w_inexact_o),
        .o_ovf     (w_ovf_o)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (w_abs == '0) ? DONE : NORM;
            NORM:    if (r_mag[NI-1]) w_next = ROUND;
            ROUND:   w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (r_state == IDLE);
        out_valid   = (r_state == DONE);
        out_data    = r_out_data;
        out_inexact = r_inexact;
        out_ovf     = r_ovf;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sign     <= 1'b0;
            r_mag      <= '0;
            r_exp      <= '0;
            r_out_data <= '0;
            r_inexact  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign <= in_data[NI-1];
                        r_mag  <= w_abs;
                        r_exp  <= EXP_INIT;
                        if (w_abs == '0) begin
                            r_out_data <= '0;
                            r_inexact  <= 1'b0;
                            r_ovf      <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    if (!r_mag[NI-1]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - EXP_ONE;
                    end
                end
                ROUND: begin
                    r_out_data <= {r_sign, w_exp_o, w_mant_o};
                    r_inexact  <= w_inexact_o;
                    r_ovf      <= w_ovf_o;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_itof_seq.sv
// Bench for fp_itof_seq: default single-precision instance plus an NX=5/NM=10 instance.
module tb_fp_itof_seq;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_inexact, a_out_ovf;
    logic [31:0] a_in_data, a_out_data;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_inexact, b_out_ovf;
    logic [31:0] b_in_data;
    logic [15:0] b_out_data;

    fp_itof_seq #(.NX(8), .NM(23), .NI(32)) u_dut_a (
        .CLK(CLK), .RST(RST),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_inexact(a_out_inexact), .out_ovf(a_out_ovf)
    );

    fp_itof_seq #(.NX(5), .NM(10), .NI(32)) u_dut_b (
        .CLK(CLK), .RST(RST),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_inexact(b_out_inexact), .out_ovf(b_out_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    typedef struct {
        logic        sel;
        logic [31:0] din;
        logic [31:0] dat;
        logic        inx;
        logic        ovf;
        int          lat;
    } vec_t;

    // Accept one word on instance sel, then count cycles until out_valid (accept edge = cycle 0).
    task automatic run_conv(input logic sel, input logic [31:0] din,
                            output logic [31:0] dat, output logic inx, output logic ovf,
                            output int lat);
        int guard;
        guard = 0;
        @(negedge CLK);
        while (!(sel ? b_in_ready : a_in_ready) && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (sel) begin b_in_valid = 1'b1; b_in_data = din; end
        else     begin a_in_valid = 1'b1; a_in_data = din; end
        @(posedge CLK);
        #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        lat = 1;
        while (!(sel ? b_out_valid : a_out_valid) && lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        dat = sel ? {16'h0, b_out_data} : a_out_data;
        inx = sel ? b_out_inexact : a_out_inexact;
        ovf = sel ? b_out_ovf : a_out_ovf;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[15];
        logic [31:0] dat;
        logic        inx, ovf;
        int          lat;
        logic [31:0] snap;
        int          seen, acc, nout, overlap;
        logic        rdy;
        logic [31:0] outs[2];

        vt[0]  = '{1'b0, 32'h00000001, 32'h3F800000, 1'b0, 1'b0, 34};
        vt[1]  = '{1'b0, 32'hFFFFFFFF, 32'hBF800000, 1'b0, 1'b0, 34};
        vt[2]  = '{1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1};
        vt[3]  = '{1'b0, 32'h80000000, 32'hCF000000, 1'b0, 1'b0, 3};
        vt[4]  = '{1'b0, 32'd16777217, 32'h4B800000, 1'b1, 1'b0, 10};
        vt[5]  = '{1'b0, 32'd16777219, 32'h4B800002, 1'b1, 1'b0, 10};
        vt[6]  = '{1'b0, 32'h7FFFFFFF, 32'h4F000000, 1'b1, 1'b0, 4};
        vt[7]  = '{1'b0, 32'd3,        32'h40400000, 1'b0, 1'b0, 33};
        vt[8]  = '{1'b0, -32'sd100,    32'hC2C80000, 1'b0, 1'b0, 28};
        vt[9]  = '{1'b0, 32'h01000000, 32'h4B800000, 1'b0, 1'b0, 10};
        vt[10] = '{1'b1, 32'h7FFFFFFF, 32'h00007C00, 1'b1, 1'b1, 4};
        vt[11] = '{1'b1, -32'sd65536,  32'h0000FC00, 1'b0, 1'b1, 18};
        vt[12] = '{1'b1, 32'd1,        32'h00003C00, 1'b0, 1'b0, 34};
        vt[13] = '{1'b1, 32'd2049,     32'h00006800, 1'b1, 1'b0, 23};
        vt[14] = '{1'b1, -32'sd2,      32'h0000C000, 1'b0, 1'b0, 33};

        RST = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        #12;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_flags", {a_out_inexact, a_out_ovf}, 0);
        RST = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_conv(vt[i].sel, vt[i].din, dat, inx, ovf, lat);
            check($sformatf("vec%0d_data", i), dat, vt[i].dat);
            check($sformatf("vec%0d_inexact", i), inx, vt[i].inx);
            check($sformatf("vec%0d_ovf", i), ovf, vt[i].ovf);
            check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_valid_drop", i), vt[i].sel ? b_out_valid : a_out_valid, 0);
        end

        // backpressure: result and flags must hold while out_ready is low
        a_out_ready = 1'b0;
        run_conv(1'b0, 32'd5, dat, inx, ovf, lat);
        check("bp_data", dat, 32'h40A00000);
        check("bp_latency", lat, 32);
        snap = a_out_data;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK);
            #1;
            check($sformatf("bp_hold_data%0d", c), a_out_data, 32'h40A00000);
            check($sformatf("bp_hold_valid%0d", c), {a_out_valid, a_in_ready}, 2'b10);
        end
        a_out_ready = 1'b1;
        @(posedge CLK);
        #1;
        check("bp_release", {a_out_valid, a_in_ready}, 2'b01);
        check("bp_snap", a_out_data, snap);

        // reset during NORM aborts the word
        @(negedge CLK);
        a_in_valid = 1'b1; a_in_data = 32'd1;
        @(posedge CLK);
        #1;
        a_in_valid = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        check("midrst_busy", a_in_ready, 0);
        RST = 1'b1;
        #1;
        check("midrst_async", {a_in_ready, a_out_valid}, 2'b10);
        check("midrst_data", a_out_data, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("midrst_next", {a_in_ready, a_out_valid}, 2'b10);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK);
            #1;
            if (a_out_valid) seen++;
        end
        check("midrst_no_stale", seen, 0);

        // back-to-back: in_valid held high across two words
        acc = 0; nout = 0; overlap = 0;
        outs[0] = '0; outs[1] = '0;
        @(negedge CLK);
        a_in_valid = 1'b1; a_in_data = 32'd7;
        for (int c = 0; c < 200 && nout < 2; c++) begin
            if (a_out_valid && a_in_ready) overlap++;
            if (a_out_valid) begin
                outs[nout] = a_out_data;
                nout++;
            end
            rdy = a_in_ready;
            @(posedge CLK);
            if (rdy && a_in_valid) begin
                acc++;
                #1;
                if (acc == 1) a_in_data = 32'd9;
                else          a_in_valid = 1'b0;
            end
            @(negedge CLK);
        end
        a_in_valid = 1'b0;
        check("b2b_first", outs[0], 32'h40E00000);
        check("b2b_second", outs[1], 32'h41100000);
        check("b2b_accepts", acc, 2);
        check("b2b_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
